dmem_wait: RTL

- Word-addressed data memory with a programmable access latency and a stall handshake.
- Sits directly downstream of the single-cycle CPU datapath. It consumes the datapath's ALU result (address) and store data, and returns load data for the result mux.
- It holds the CPU (stall freezes PC and register writes) until a multi-cycle access completes, so the core can be exercised against slow memory.

---
 rtl/dmem_wait.sv | 97 +++++++++
 1 files changed

// File: rtl/dmem_wait.sv
// Word-addressed data memory with a programmable access latency.
// Holds the CPU with a stall handshake until each aligned access completes.
module dmem_wait #(
  parameter int n       = 32,
  parameter int DEPTH   = 6,
  parameter int LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memread,
  input  logic         memwrite,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic         stall,
  output logic         misalign
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACCESS   = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("dmem_wait: LATENCY must be in 1..15");
    end
  endgenerate

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [DEPTH-1:0] idx_q;
  logic [n-1:0]     data_q;
  logic             wr_q;
  logic [n-1:0]     mem [2**DEPTH];

  logic             req;
  logic             aligned;
  logic             accept;
  logic             finish;
  logic             op_wr;
  logic [DEPTH-1:0] in_idx;
  logic [DEPTH-1:0] op_idx;
  logic [n-1:0]     op_data;
  logic             unused_addr;

  assign unused_addr = ^addr[n-1:DEPTH+2];
  assign in_idx      = addr[DEPTH+1:2];
  assign req         = memread | memwrite;
  assign aligned     = (addr[1:0] == 2'b00);
  assign accept      = reset && (state == IDLE) && req && aligned;

  // With LATENCY=1 the access completes on the accepting edge, before anything is latched.
  assign finish  = (accept && (LATENCY == 1)) || (reset && (state == ACCESS) && (cnt == 4'd1));
  assign op_wr   = (state == IDLE) ? memwrite  : wr_q;
  assign op_idx  = (state == IDLE) ? in_idx    : idx_q;
  assign op_data = (state == IDLE) ? writedata : data_q;

  assign stall    = accept || (reset && (state == ACCESS));
  assign misalign = reset && (state == IDLE) && req && !aligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      readdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q  <= in_idx;
            data_q <= writedata;
            wr_q   <= memwrite;
            cnt    <= CNT_INIT;
            state  <= (LATENCY == 1) ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finish && !op_wr) readdata <= mem[op_idx];
    end
  end

  // Storage is deliberately not reset; finish is already gated off while reset is low.
  always_ff @(posedge clk) begin
    if (finish && op_wr) mem[op_idx] <= op_data;
  end

endmodule
